// File: rtl/conv_1x1_pw_project.sv
// Pointwise 1x1 projection: accumulates IN_CHANNELS beats per pixel
// into OUT_CHANNELS parallel sums, then streams them out one per beat.
module conv_1x1_pw_project #(
  parameter int IN_CHANNELS  = 16,
  parameter int OUT_CHANNELS = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic [7:0]                   channel_in,
  input  logic [7:0]                   row_in,
  input  logic [7:0]                   col_in,
  output logic                         ready,
  output logic                         valid_out,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [7:0]                   channel_out,
  output logic [7:0]                   row_out,
  output logic [7:0]                   col_out,
  output logic                         seq_err
);

  localparam int KW =
    (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam logic [7:0] LAST_CH =
    8'(IN_CHANNELS - 1);
  localparam logic [KW-1:0] LAST_K =
    KW'(OUT_CHANNELS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ~SAT_MAX;

  typedef enum logic {
    ACCUM,
    EMIT
  } state_t;

  state_t                       state_q;
  logic                         ready_q;
  logic                         valid_q;
  logic                         seq_err_q;
  logic [7:0]                   exp_ch_q;
  logic [KW-1:0]                k_q;
  logic [KW-1:0]                k_nx;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic [7:0]                   ch_out_q;
  logic [7:0]                   row_q;
  logic [7:0]                   col_q;

  logic signed [ACC_WIDTH-1:0] acc_q [OUT_CHANNELS];
  logic signed [ACC_WIDTH-1:0] acc_d [OUT_CHANNELS];
  logic signed [ACC_WIDTH-1:0] prod  [OUT_CHANNELS];
  logic signed [ACC_WIDTH-1:0] wgt   [OUT_CHANNELS];
  logic [7:0]                  wbits [OUT_CHANNELS];

  // Q.7 rescale with floor rounding, clamped to the output range
  function automatic logic signed [DATA_WIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> 7;
    if (s > SAT_MAX) s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return DATA_WIDTH'(s);
  endfunction

  assign k_nx        = k_q + KW'(1);
  assign ready       = ready_q;
  assign valid_out   = valid_q;
  assign seq_err     = seq_err_q;
  assign data_out    = data_q;
  assign channel_out = ch_out_q;
  assign row_out     = row_q;
  assign col_out     = col_q;

  // Weights are generated arithmetically; the 8-bit wrap minus 128
  // is the same as flipping the MSB of the wrapped index.
  // Channel 0 always starts a fresh sum, anything else adds on.
  always_comb begin
    for (int o = 0; o < OUT_CHANNELS; o++) begin
      wbits[o] = 8'(o * IN_CHANNELS + int'(channel_in) + 7);
      wgt[o]   = ACC_WIDTH'($signed({~wbits[o][7],
                                     wbits[o][6:0]}));
      prod[o]  = ACC_WIDTH'(data_in) * wgt[o];
      acc_d[o] = (channel_in == 8'd0) ? prod[o]
                                      : acc_q[o] + prod[o];
    end
  end

  // Control FSM, accumulators and registered output beat
  always_ff @(posedge clk) begin
    seq_err_q <= 1'b0;
    if (rst) begin
      state_q  <= ACCUM;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      exp_ch_q <= '0;
      k_q      <= '0;
      data_q   <= '0;
      ch_out_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      for (int o = 0; o < OUT_CHANNELS; o++) begin
        acc_q[o] <= '0;
      end
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (valid_in) begin
            if (channel_in == exp_ch_q) begin
              acc_q <= acc_d;
              if (exp_ch_q == 8'd0) begin
                row_q <= row_in;
                col_q <= col_in;
              end
              if (exp_ch_q == LAST_CH) begin
                state_q  <= EMIT;
                ready_q  <= 1'b0;
                valid_q  <= 1'b1;
                exp_ch_q <= '0;
                k_q      <= '0;
                data_q   <= sat(acc_d[0]);
                ch_out_q <= '0;
              end else begin
                exp_ch_q <= exp_ch_q + 8'd1;
              end
            end else begin
              seq_err_q <= 1'b1;
              if (channel_in == 8'd0) begin
                acc_q    <= acc_d;
                row_q    <= row_in;
                col_q    <= col_in;
                exp_ch_q <= 8'd1;
              end else begin
                exp_ch_q <= '0;
              end
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (k_q == LAST_K) begin
              state_q <= ACCUM;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
              k_q     <= '0;
            end else begin
              k_q      <= k_nx;
              data_q   <= sat(acc_q[k_nx]);
              ch_out_q <= 8'(k_nx);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_1x1_pw_project.sv
// Bench for conv_1x1_pw_project: directed scenarios plus randomized
// pixels checked against an arithmetic reference of the projection.
module tb_conv_1x1_pw_project;

  localparam int IN  = 16;
  localparam int OUT = 8;
  localparam int DW  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic [7:0]           channel_in;
  logic [7:0]           row_in;
  logic [7:0]           col_in;
  logic                 ready;
  logic                 valid_out;
  logic                 out_ready;
  logic signed [DW-1:0] data_out;
  logic [7:0]           channel_out;
  logic [7:0]           row_out;
  logic [7:0]           col_out;
  logic                 seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int data;
    int ch;
    int row;
    int col;
  } beat_t;

  beat_t got[$];
  int    pix[IN];

  always #5 clk = ~clk;

  conv_1x1_pw_project #(
    .IN_CHANNELS (IN),
    .OUT_CHANNELS(OUT),
    .DATA_WIDTH  (DW),
    .ACC_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .channel_in (channel_in),
    .row_in     (row_in),
    .col_in     (col_in),
    .ready      (ready),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .channel_out(channel_out),
    .row_out    (row_out),
    .col_out    (col_out),
    .seq_err    (seq_err)
  );

  function automatic int wref(int o, int i);
    return ((o * IN + i + 7) % 256) - 128;
  endfunction

  // Exact dot product, floor-divided by 128, then clamped
  function automatic int model(int o);
    longint s = 0;
    for (int i = 0; i < IN; i++)
      s += longint'(pix[i]) * longint'(wref(o, i));
    s = s >>> 7;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic send_beat(input int ch, input int d,
                           input int r, input int c);
    @(negedge clk);
    valid_in   = 1'b1;
    channel_in = 8'(ch);
    data_in    = DW'(d);
    row_in     = 8'(r);
    col_in     = 8'(c);
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
  endtask

  // gaps: 0 none, 1 every other beat, 2 random
  task automatic send_pixel(input int r, input int c,
                            input int gaps);
    for (int i = 0; i < IN; i++) begin
      send_beat(i, pix[i], r, c);
      if (i < IN - 1) begin
        if (gaps == 1 && (i % 2) == 0) idle_cycle();
        if (gaps == 2 && $urandom_range(0, 1) == 1) idle_cycle();
      end
    end
  endtask

  // Gathers accepted output beats; mode 1 randomizes out_ready.
  task automatic collect(input int mode, input int stall_ch,
                         input int stall_len, input bit noise,
                         output int first_idx, output int last_idx,
                         output int hold_bad, output int seq_cnt,
                         output bit timeout);
    int    cyc = 0;
    int    stalled = 0;
    int    hold_d = 0;
    int    hold_c = 0;
    beat_t b;
    got.delete();
    first_idx = -1;
    last_idx  = -1;
    hold_bad  = 0;
    seq_cnt   = 0;
    timeout   = 1'b0;
    while (got.size() < OUT) begin
      @(negedge clk);
      if (cyc > 400) begin
        valid_in = 1'b0;
        timeout  = 1'b1;
        break;
      end
      if (seq_err) seq_cnt++;
      if (valid_out && first_idx < 0) first_idx = cyc;
      if (valid_out && int'(channel_out) == stall_ch &&
          stalled < stall_len) begin
        if (stalled == 0) begin
          hold_d = int'(data_out);
          hold_c = int'(channel_out);
        end else if (int'(data_out) != hold_d ||
                     int'(channel_out) != hold_c) begin
          hold_bad++;
        end
        if (ready) hold_bad++;
        out_ready = 1'b0;
        stalled++;
      end else if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (noise && valid_out && int'(channel_out) != OUT - 1) begin
        valid_in   = 1'($urandom_range(0, 1));
        channel_in = 8'($urandom_range(0, IN - 1));
        data_in    = DW'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      if (valid_out && out_ready) begin
        b.data = int'(data_out);
        b.ch   = int'(channel_out);
        b.row  = int'(row_out);
        b.col  = int'(col_out);
        got.push_back(b);
        last_idx = cyc;
      end
      cyc++;
    end
  endtask

  task automatic set_single_tap();
    for (int i = 0; i < IN; i++) pix[i] = (i == 0) ? 128 : 0;
  endtask

  task automatic set_random();
    for (int i = 0; i < IN; i++)
      pix[i] = int'($signed(DW'($urandom)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    out_ready = 1'b1;
    channel_in = '0;
    data_in = '0;
    row_in = '0;
    col_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests += 7;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got=%b exp=1", ready);
    end
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got=%b exp=0", valid_out);
    end
    if (seq_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_seq_err got=%b exp=0", seq_err);
    end
    if (data_out !== '0) begin
      n_fail++; $display("FAIL rst_data got=%0d exp=0", data_out);
    end
    if (channel_out !== 8'd0) begin
      n_fail++; $display("FAIL rst_ch got=%0d exp=0", channel_out);
    end
    if (row_out !== 8'd0) begin
      n_fail++; $display("FAIL rst_row got=%0d exp=0", row_out);
    end
    if (col_out !== 8'd0) begin
      n_fail++; $display("FAIL rst_col got=%0d exp=0", col_out);
    end
    rst = 1'b0;
  endtask

  // Single weight tap; optional gaps and EMIT-time valid_in noise
  task automatic test_single_tap(input int gaps, input bit noise);
    int fi, li, hb, sc;
    bit to;
    set_single_tap();
    send_pixel(3, 5, gaps);
    collect(0, -1, 0, noise, fi, li, hb, sc, to);
    n_tests += 5;
    if (to) begin
      n_fail++; $display("FAIL tap_timeout got=%0d exp=%0d",
                         got.size(), OUT);
    end
    if (got.size() != OUT) begin
      n_fail++; $display("FAIL tap_count got=%0d exp=%0d",
                         got.size(), OUT);
    end
    if (fi != 0) begin
      n_fail++; $display("FAIL tap_latency got=%0d exp=0", fi);
    end
    if (li != OUT - 1) begin
      n_fail++; $display("FAIL tap_drain got=%0d exp=%0d", li, OUT - 1);
    end
    if (sc != 0) begin
      n_fail++; $display("FAIL tap_seq_err got=%0d exp=0", sc);
    end
    for (int k = 0; k < got.size(); k++) begin
      n_tests += 4;
      if (got[k].data != -121 + 16 * k) begin
        n_fail++; $display("FAIL tap_data[%0d] got=%0d exp=%0d",
                           k, got[k].data, -121 + 16 * k);
      end
      if (got[k].ch != k) begin
        n_fail++; $display("FAIL tap_ch[%0d] got=%0d exp=%0d",
                           k, got[k].ch, k);
      end
      if (got[k].row != 3) begin
        n_fail++; $display("FAIL tap_row[%0d] got=%0d exp=3",
                           k, got[k].row);
      end
      if (got[k].col != 5) begin
        n_fail++; $display("FAIL tap_col[%0d] got=%0d exp=5",
                           k, got[k].col);
      end
    end
  endtask

  task automatic test_saturation();
    int fi, li, hb, sc;
    bit to;
    for (int i = 0; i < IN; i++) pix[i] = 32767;
    send_pixel(1, 2, 0);
    collect(0, -1, 0, 1'b0, fi, li, hb, sc, to);
    n_tests++;
    if (got.size() != OUT) begin
      n_fail++; $display("FAIL sat_count got=%0d exp=%0d",
                         got.size(), OUT);
    end else begin
      n_tests += 2;
      if (got[0].data != -32768) begin
        n_fail++; $display("FAIL sat_ch0 got=%0d exp=-32768",
                           got[0].data);
      end
      if (got[7].data != -6144) begin
        n_fail++; $display("FAIL sat_ch7 got=%0d exp=-6144",
                           got[7].data);
      end
      for (int k = 0; k < OUT; k++) begin
        n_tests++;
        if (got[k].data != model(k)) begin
          n_fail++; $display("FAIL sat_data[%0d] got=%0d exp=%0d",
                             k, got[k].data, model(k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fi, li, hb, sc;
    bit to;
    set_random();
    send_pixel(10, 20, 0);
    collect(0, 2, 5, 1'b0, fi, li, hb, sc, to);
    n_tests += 3;
    if (hb != 0) begin
      n_fail++; $display("FAIL bp_hold got=%0d exp=0", hb);
    end
    if (got.size() != OUT) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=%0d",
                         got.size(), OUT);
    end
    if (li != OUT - 1 + 5) begin
      n_fail++; $display("FAIL bp_drain got=%0d exp=%0d",
                         li, OUT - 1 + 5);
    end
    for (int k = 0; k < got.size(); k++) begin
      n_tests += 2;
      if (got[k].ch != k) begin
        n_fail++; $display("FAIL bp_ch[%0d] got=%0d exp=%0d",
                           k, got[k].ch, k);
      end
      if (got[k].data != model(k)) begin
        n_fail++; $display("FAIL bp_data[%0d] got=%0d exp=%0d",
                           k, got[k].data, model(k));
      end
    end
  endtask

  task automatic test_order_error();
    int fi, li, hb, sc;
    int errs = 0;
    int vouts = 0;
    bit to;
    send_beat(0, 100, 4, 4);
    send_beat(1, 200, 4, 4);
    send_beat(2, 300, 4, 4);
    send_beat(5, 400, 4, 4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (seq_err) errs++;
      if (valid_out) vouts++;
    end
    n_tests += 2;
    if (errs != 1) begin
      n_fail++; $display("FAIL oe_pulses got=%0d exp=1", errs);
    end
    if (vouts != 0) begin
      n_fail++; $display("FAIL oe_valid got=%0d exp=0", vouts);
    end
    set_single_tap();
    send_pixel(7, 9, 0);
    collect(0, -1, 0, 1'b0, fi, li, hb, sc, to);
    n_tests += 2;
    if (sc != 0) begin
      n_fail++; $display("FAIL oe_seq_after got=%0d exp=0", sc);
    end
    if (got.size() != OUT) begin
      n_fail++; $display("FAIL oe_count got=%0d exp=%0d",
                         got.size(), OUT);
    end else begin
      n_tests += 2;
      if (got[0].data != -121) begin
        n_fail++; $display("FAIL oe_ch0 got=%0d exp=-121",
                           got[0].data);
      end
      if (got[0].row != 7) begin
        n_fail++; $display("FAIL oe_row got=%0d exp=7", got[0].row);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int fi, li, hb, sc;
    int vouts = 0;
    bit found = 1'b0;
    bit to;
    set_random();
    send_pixel(2, 2, 0);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
      out_ready = 1'b1;
      if (valid_out && channel_out == 8'd3) found = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests += 3;
    if (!found) begin
      n_fail++; $display("FAIL rme_reach got=0 exp=1");
    end
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL rme_valid got=%b exp=0", valid_out);
    end
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL rme_ready got=%b exp=1", ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (valid_out) vouts++;
    end
    n_tests++;
    if (vouts != 0) begin
      n_fail++; $display("FAIL rme_stale got=%0d exp=0", vouts);
    end
    set_random();
    send_pixel(6, 8, 0);
    collect(0, -1, 0, 1'b0, fi, li, hb, sc, to);
    n_tests++;
    if (got.size() != OUT) begin
      n_fail++; $display("FAIL rme_count got=%0d exp=%0d",
                         got.size(), OUT);
    end
    for (int k = 0; k < got.size(); k++) begin
      n_tests += 2;
      if (got[k].ch != k) begin
        n_fail++; $display("FAIL rme_ch[%0d] got=%0d exp=%0d",
                           k, got[k].ch, k);
      end
      if (got[k].data != model(k)) begin
        n_fail++; $display("FAIL rme_data[%0d] got=%0d exp=%0d",
                           k, got[k].data, model(k));
      end
    end
  endtask

  task automatic test_random();
    int fi, li, hb, sc, r, c;
    bit to;
    for (int p = 0; p < 8; p++) begin
      set_random();
      r = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      send_pixel(r, c, 2);
      collect(1, -1, 0, 1'($urandom_range(0, 1)),
              fi, li, hb, sc, to);
      n_tests += 2;
      if (got.size() != OUT) begin
        n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d",
                           p, got.size(), OUT);
      end
      if (sc != 0) begin
        n_fail++; $display("FAIL rnd_seq[%0d] got=%0d exp=0", p, sc);
      end
      for (int k = 0; k < got.size(); k++) begin
        n_tests += 4;
        if (got[k].data != model(k)) begin
          n_fail++; $display("FAIL rnd_data[%0d/%0d] got=%0d exp=%0d",
                             p, k, got[k].data, model(k));
        end
        if (got[k].ch != k) begin
          n_fail++; $display("FAIL rnd_ch[%0d/%0d] got=%0d exp=%0d",
                             p, k, got[k].ch, k);
        end
        if (got[k].row != r) begin
          n_fail++; $display("FAIL rnd_row[%0d/%0d] got=%0d exp=%0d",
                             p, k, got[k].row, r);
        end
        if (got[k].col != c) begin
          n_fail++; $display("FAIL rnd_col[%0d/%0d] got=%0d exp=%0d",
                             p, k, got[k].col, c);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tap(0, 1'b0);
    test_saturation();
    test_backpressure();
    test_order_error();
    test_reset_mid_emit();
    test_single_tap(1, 1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_1x1_pw_project.md
CONV_1X1_PW_PROJECT -- requirements
Module: conv_1x1_pw_project

Interface
REQ-001 The block SHALL have parameter IN_CHANNELS, default 16, meaning input channels per pixel (>=2).
REQ-002 The block SHALL have parameter OUT_CHANNELS, default 8, meaning projected output channels per pixel (>=1).
REQ-003 The block SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width, fixed-point with 7 fraction bits.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 32, meaning signed accumulator width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port valid_in, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits: signed depthwise-conv result.
REQ-009 The block SHALL have ports channel_in, row_in and col_in, each input, 8 bits: channel and pixel coordinate of the input beat.
REQ-010 The block SHALL have port ready, output, 1 bit: the block accepts input this cycle.
REQ-011 The block SHALL have port valid_out, output, 1 bit: output beat valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-013 The block SHALL have port data_out, output, DATA_WIDTH bits: signed projected value.
REQ-014 The block SHALL have ports channel_out, row_out and col_out, each output, 8 bits: output channel and pixel coordinate.
REQ-015 The block SHALL have port seq_err, output, 1 bit: one-cycle pulse on a channel-order violation.

Function
REQ-016 The block SHALL accept an input beat only when valid_in && ready; ready SHALL be 1 exactly in state ACCUM.
REQ-017 The block SHALL implement two states: ACCUM and EMIT.
REQ-018 In ACCUM, the block SHALL keep an expected-channel counter exp_ch, reset to 0; inputs for a pixel arrive channel 0..IN_CHANNELS-1 in order, with gaps allowed.
REQ-019 The weight SHALL be w(o,i) = ((o*IN_CHANNELS + i + 7) mod 256) - 128, an 8-bit signed Q1.7 value computed with no memory file.
REQ-020 On an accepted beat with channel_in == exp_ch == 0, the block SHALL load acc[o] = data_in*w(o,0) for every o and latch row_in/col_in.
REQ-021 On an accepted beat with channel_in == exp_ch != 0, the block SHALL apply acc[o] += data_in*w(o,channel_in) for all o in parallel, full-precision signed, with no wrap at ACC_WIDTH=32.
REQ-022 An accepted beat with channel_in != exp_ch SHALL pulse seq_err for one cycle.
REQ-023 After a seq_err beat, the partial pixel SHALL be discarded; if channel_in == 0 the beat SHALL start a new pixel per REQ-020 (exp_ch becomes 1), otherwise exp_ch SHALL become 0 and the beat is dropped.
REQ-024 On acceptance of channel IN_CHANNELS-1 (in order), the block SHALL go to EMIT on the next edge, with exp_ch reset to 0 and out index k = 0.
REQ-025 In EMIT, valid_out SHALL be 1 and the outputs SHALL present data_out = sat(acc[k] >>> 7), channel_out = k, and the latched row/col.
REQ-026 The output fields SHALL be registered and stay stable while valid_out && !out_ready.
REQ-027 On valid_out && out_ready, k SHALL increment; when k == OUT_CHANNELS-1 is accepted, the block SHALL return to ACCUM (ready=1) on the next edge.
REQ-028 Latency SHALL be as follows: the first valid_out is high in the cycle after the last input beat is accepted; with out_ready held at 1, the pixel drains in OUT_CHANNELS cycles.
REQ-029 sat() SHALL be an arithmetic right shift (floor) followed by clamping to [-32768, 32767].
REQ-030 valid_in presented while in EMIT SHALL be ignored, and no state SHALL change because of it.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL enter ACCUM with exp_ch=0 and k=0.
REQ-032 While rst=1, the outputs SHALL be ready=1 (from the first cycle after reset), valid_out=0, seq_err=0, and data_out, channel_out, row_out and col_out all 0.
REQ-033 Accumulators SHALL clear to 0 on reset.
REQ-034 A reset asserted mid-ACCUM or mid-EMIT SHALL abandon the pixel, with no further valid_out for that pixel.

Verification
REQ-035 The bench SHALL cover single-tap: ch0 data=128, ch1..15 data=0, row=3, col=5, out_ready=1 -> 8 beats, one per cycle, starting the cycle after ch15, with data_out = -121, -105, -89, -73, -57, -41, -25, -9 and row_out=3, col_out=5.
REQ-036 The bench SHALL cover saturation: all 16 channels data=32767 -> ch0 data_out=-32768 (clamped), ch7 data_out=-6144.
REQ-037 The bench SHALL cover backpressure: out_ready=0 for 5 cycles during the ch2 output -> data_out and channel_out=2 are held and ready=0 throughout; release gives exactly 8 beats total with no duplicates.
REQ-038 The bench SHALL cover order error: channels 0,1,2 then 5 -> one seq_err pulse and no output; next 0..15 with ch0=128 (rest 0) -> ch0 output -121.
REQ-039 The bench SHALL cover reset mid-EMIT: rst=1 at the ch3 output -> next cycle valid_out=0, ready=1; a fresh 16-beat pixel then produces normal output starting at channel_out=0.
REQ-040 The bench SHALL cover gapped input: valid_in toggled 1/0 across 16 beats -> results identical to REQ-035, and valid_in during EMIT leaves the results unaffected.
